// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a single beat of output storage.
// Optional per-channel transfer counters are enabled by defining DEMUX_CNT_EN.
module stream_demux_1to4 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [4*CNT_W-1:0] out_cnt
);

  logic [WIDTH-1:0] data_q;
  logic [1:0]       sel_q;
  logic             full_q;
  logic             accept;
  logic             xfer;

  // Only the selected channel's ready matters; the others never gate anything.
  assign xfer      = full_q && out_ready[sel_q];
  assign in_ready  = !full_q || out_ready[sel_q];
  assign accept    = in_valid && in_ready;
  assign out_valid = full_q ? (4'b0001 << sel_q) : 4'b0000;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      sel_q  <= 2'd0;
    end else if (accept) begin
      full_q <= 1'b1;
      data_q <= in_data;
      sel_q  <= in_sel;
    end else if (xfer) begin
      full_q <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst)
        cnt_q[i] <= '0;
      else if (out_valid[i] && out_ready[i])
        cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign out_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  assign out_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Bench for stream_demux_1to4: directed vector table, hand sequences and random traffic
// checked against a queue-based model with per-channel scoreboards.
module tb_stream_demux_1to4;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
`ifdef DEMUX_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [4*CNT_W-1:0] out_cnt;

  stream_demux_1to4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t            pend[$];
  logic [WIDTH-1:0] exp_ch[4][$];
  int               cnt[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*CNT_W-1:0] exp_cnt();
    logic [4*CNT_W-1:0] v = '0;
    if (CNT_ON)
      for (int i = 0; i < 4; i++) v[i*CNT_W +: CNT_W] = CNT_W'(cnt[i] % (1 << CNT_W));
    return v;
  endfunction

  // Compare DUT against the model in the current cycle (called away from the edge).
  task automatic model_check();
    logic [3:0] ev;
    logic       er;
    ev = (pend.size() > 0) ? (4'b0001 << pend[0].sel) : 4'b0000;
    er = (pend.size() == 0) ? 1'b1 : out_ready[pend[0].sel];
    check("model_out_valid", 64'(out_valid), 64'(ev));
    if (pend.size() > 0) check("model_out_data", 64'(out_data), 64'(pend[0].data));
    check("model_in_ready", 64'(in_ready), 64'(er));
    check("model_out_cnt", 64'(out_cnt), 64'(exp_cnt()));
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_ch[i].size() == 0) begin
            check("scoreboard_spurious", 64'(i), 64'hFFFF);
          end else begin
            check("scoreboard_data", 64'(out_data), 64'(exp_ch[i].pop_front()));
          end
        end
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_update();
    bit deliver, accept;
    if (rst) begin
      if (pend.size() > 0) void'(exp_ch[pend[0].sel].pop_back());
      pend.delete();
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      return;
    end
    deliver = (pend.size() > 0) && out_ready[pend[0].sel];
    accept  = in_valid && ((pend.size() == 0) || deliver);
    if (deliver) begin
      cnt[pend[0].sel]++;
      void'(pend.pop_front());
    end
    if (accept) begin
      pend.push_back('{sel: in_sel, data: in_data});
      exp_ch[in_sel].push_back(in_data);
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  typedef struct {
    logic             v;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
    logic [3:0]       rdy;
    logic [3:0]       ev;
    logic [WIDTH-1:0] ed;
    logic             er;
  } vec_t;

  vec_t vec[20];

  initial begin
    // Beats 2 and 4 of the sequence in the table, plus stall and replace-on-drain cases.
    vec[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b1111, 4'b0000, 32'h0,        1'b1};
    vec[1]  = '{1'b1, 2'd0, 32'hA0A0A0A0, 4'b1111, 4'b0100, 32'hDEADBEEF, 1'b1};
    vec[2]  = '{1'b1, 2'd1, 32'hA1A1A1A1, 4'b1111, 4'b0001, 32'hA0A0A0A0, 1'b1};
    vec[3]  = '{1'b1, 2'd2, 32'hA2A2A2A2, 4'b1111, 4'b0010, 32'hA1A1A1A1, 1'b1};
    vec[4]  = '{1'b1, 2'd3, 32'hA3A3A3A3, 4'b1111, 4'b0100, 32'hA2A2A2A2, 1'b1};
    vec[5]  = '{1'b0, 2'd0, 32'h0,        4'b1111, 4'b1000, 32'hA3A3A3A3, 1'b1};
    vec[6]  = '{1'b0, 2'd3, 32'h12345678, 4'b1111, 4'b0000, 32'h0,        1'b1};
    vec[7]  = '{1'b1, 2'd1, 32'hB1B1B1B1, 4'b1101, 4'b0000, 32'h0,        1'b1};
    for (int k = 8; k < 13; k++)
      vec[k] = '{1'b1, 2'd0, 32'hC0C0C0C0, 4'b1101, 4'b0010, 32'hB1B1B1B1, 1'b0};
    vec[13] = '{1'b1, 2'd0, 32'hC0C0C0C0, 4'b1111, 4'b0010, 32'hB1B1B1B1, 1'b1};
    vec[14] = '{1'b0, 2'd0, 32'h0,        4'b1111, 4'b0001, 32'hC0C0C0C0, 1'b1};
    vec[15] = '{1'b1, 2'd3, 32'hD3D3D3D3, 4'b0000, 4'b0000, 32'h0,        1'b1};
    vec[16] = '{1'b1, 2'd0, 32'hE0E0E0E0, 4'b1000, 4'b1000, 32'hD3D3D3D3, 1'b1};
    vec[17] = '{1'b0, 2'd0, 32'h0,        4'b0000, 4'b0001, 32'hE0E0E0E0, 1'b0};
    vec[18] = '{1'b0, 2'd0, 32'h0,        4'b0001, 4'b0001, 32'hE0E0E0E0, 1'b1};
    vec[19] = '{1'b0, 2'd0, 32'h0,        4'b1111, 4'b0000, 32'h0,        1'b1};

    rst = 1'b1;
    drive(1'b0, 2'd0, '0, 4'b0000);
    repeat (2) begin @(posedge clk); model_update(); end
    #1;
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_out_data", 64'(out_data), 64'h0);
    check("reset_in_ready", 64'(in_ready), 64'h1);
    check("reset_out_cnt", 64'(out_cnt), 64'h0);

    for (int k = 0; k < 20; k++) begin
      drive(vec[k].v, vec[k].sel, vec[k].data, vec[k].rdy);
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(vec[k].ev));
      if (vec[k].ev != 4'b0000)
        check($sformatf("vec%0d_out_data", k), 64'(out_data), 64'(vec[k].ed));
      check($sformatf("vec%0d_in_ready", k), 64'(in_ready), 64'(vec[k].er));
      model_check();
      @(posedge clk);
      model_update();
      #1;
    end

    // Reset in the middle of a stall discards the pending beat.
    drive(1'b1, 2'd2, 32'hF2F2F2F2, 4'b0000); step();
    drive(1'b0, 2'd0, '0, 4'b1011); step();
    check("stall_out_valid", 64'(out_valid), 64'h4);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_out_data", 64'(out_data), 64'h0);
    check("midrst_in_ready", 64'(in_ready), 64'h1);
    check("midrst_out_cnt", 64'(out_cnt), 64'h0);
    drive(1'b0, 2'd0, '0, 4'b1111);
    repeat (3) step();
    check("midrst_no_delivery", 64'(out_valid), 64'h0);

    // 17 transfers on channel 2: counter wraps through zero to one.
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 2'd2, WIDTH'(32'h2000 + k), 4'b1111); step();
    end
    drive(1'b0, 2'd0, '0, 4'b1111); step(); step();
    check("wrap_out_cnt", 64'(out_cnt), CNT_ON ? 64'h0100 : 64'h0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom(),
            4'($urandom_range(0, 15)));
      step();
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, '0, 4'b1111); step(); step();
    for (int i = 0; i < 4; i++)
      check($sformatf("scoreboard_empty_ch%0d", i), 64'(exp_ch[i].size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
